// File: rtl/ddr3_pll_pkg.sv
// ddr3_pll_pkg: shared FSM states, PHASESEL/PHASEDIR encodings and helpers for PLL phase stepping.
package ddr3_pll_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, DONE} state_t;

    localparam logic [1:0] SEL_OP  = 2'd0;
    localparam logic [1:0] SEL_OS  = 2'd1;
    localparam logic [1:0] SEL_OS2 = 2'd2;
    localparam logic [1:0] SEL_OS3 = 2'd3;

    localparam logic DIR_DELAY = 1'b0;
    localparam logic DIR_LEAD  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/phase_pos_tracker.sv
// phase_pos_tracker: per-output accumulated phase position, one counter per PLL output.
// Ports: clk/rst (sync active-high), step_i (one-cycle strobe as PHASESTEP falls),
//        sel_i (output being stepped), dir_i (DIR_DELAY adds, DIR_LEAD subtracts),
//        pos_o (four POS_W positions, wrapping modulo 2^POS_W).
module phase_pos_tracker
    import ddr3_pll_pkg::*;
#(
    parameter int POS_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_i,
    input  logic [1:0]            sel_i,
    input  logic                  dir_i,
    output logic [3:0][POS_W-1:0] pos_o
);

    logic [3:0][POS_W-1:0] pos_q;

    always_ff @(posedge clk) begin
        if (rst)
            pos_q <= '0;
        else if (step_i)
            pos_q[sel_i] <= (dir_i == DIR_LEAD) ? pos_q[sel_i] - 1'b1 : pos_q[sel_i] + 1'b1;
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: drives ECP5 EHXPLLL PHASESEL/PHASEDIR/PHASESTEP from valid/ready phase-shift requests.
// Ports: clk, rst (sync active-high), pll_lock (gates acceptance only),
//        req_valid/req_ready/req_sel/req_dir/req_cnt (request handshake),
//        done (one-cycle completion), busy, phasesel/phasedir/phasestep (to the PLL),
//        pos_op/pos_os/pos_os2/pos_os3 (accumulated positions, only with PLL_PHASE_POS_EN defined).
module pll_phase_stepper
    import ddr3_pll_pkg::*;
#(
    parameter int SETUP_CYC  = 4,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 8,
    parameter int POS_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_cnt,
    output logic             done,
    output logic             busy,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep
`ifdef PLL_PHASE_POS_EN
    ,
    output logic [POS_W-1:0] pos_op,
    output logic [POS_W-1:0] pos_os,
    output logic [POS_W-1:0] pos_os2,
    output logic [POS_W-1:0] pos_os3
`endif
);

    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC)) + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic             dir_q;
    logic             fire;
    logic             last;

    assign fire = req_valid && req_ready;

    // last cycle of the timed phase currently held in state_q
    assign last = cyc_q == ((state_q == SETUP) ? CW'(SETUP_CYC - 1) :
                            (state_q == PULSE) ? CW'(PULSE_CYC - 1) : CW'(SETTLE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            if (fire) begin
                sel_q <= req_sel;
                dir_q <= req_dir;
                cnt_q <= req_cnt;
            end else if (state_q == SETTLE && last) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fire ? ((req_cnt == '0) ? DONE : SETUP) : IDLE;
            SETUP:   state_d = last ? PULSE : SETUP;
            PULSE:   state_d = last ? SETTLE : PULSE;
            // later steps skip SETUP: sel/dir have been stable since the first one
            SETTLE:  state_d = last ? ((cnt_q == CNT_W'(1)) ? DONE : PULSE) : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cyc_d = (state_d != state_q || state_q == IDLE) ? '0 : cyc_q + 1'b1;
    end

    always_comb begin
        req_ready = state_q == IDLE && pll_lock && !rst;
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        phasestep = state_q == PULSE;
        phasesel  = sel_q;
        phasedir  = dir_q;
    end

`ifdef PLL_PHASE_POS_EN
    logic [3:0][POS_W-1:0] pos;

    phase_pos_tracker #(.POS_W(POS_W)) u_pos (
        .clk    (clk),
        .rst    (rst),
        .step_i (state_q == PULSE && last),
        .sel_i  (sel_q),
        .dir_i  (dir_q),
        .pos_o  (pos)
    );

    assign pos_op  = pos[SEL_OP];
    assign pos_os  = pos[SEL_OS];
    assign pos_os2 = pos[SEL_OS2];
    assign pos_os3 = pos[SEL_OS3];
`endif

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb_pll_phase_stepper: scoreboard bench for pll_phase_stepper against a timing/position reference model.
module tb_pll_phase_stepper;

    localparam int S = 4;
    localparam int P = 4;
    localparam int T = 8;
    localparam int CNT_W = 8;
    localparam int POS_W = 3;

    logic clk = 0;
    logic rst = 1;
    logic pll_lock = 0;
    logic req_valid = 0;
    logic [1:0] req_sel = 0;
    logic req_dir = 0;
    logic [CNT_W-1:0] req_cnt = 0;
    logic req_ready, done, busy, phasedir, phasestep;
    logic [1:0] phasesel;
`ifdef PLL_PHASE_POS_EN
    logic [POS_W-1:0] pos_op, pos_os, pos_os2, pos_os3;
    logic [POS_W-1:0] mpos [4];
`endif

    pll_phase_stepper #(
        .SETUP_CYC(S), .PULSE_CYC(P), .SETTLE_CYC(T), .CNT_W(CNT_W), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dir(req_dir), .req_cnt(req_cnt),
        .done(done), .busy(busy),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep)
`ifdef PLL_PHASE_POS_EN
        , .pos_op(pos_op), .pos_os(pos_os), .pos_os2(pos_os2), .pos_os3(pos_os3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         acc;
        int         d_done;
        logic [1:0] sel;
        logic       dir;
        int         cnt;
    } req_t;

    req_t sb[$];
    int   cyc = 0;
    logic rst_q = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // monitor: every cycle compares the handshake/PLL pins with the model of the active request
    logic [1:0] last_sel = 0;
    logic       last_dir = 0;
    logic [6:0] m_exp, m_act;
    req_t       m_r;
    bit         m_a;
    int         m_d;

    always @(negedge clk) begin
        if (rst_q) begin
            while (sb.size() > 0 && sb[0].acc <= cyc) void'(sb.pop_front());
            last_sel = 0;
            last_dir = 0;
`ifdef PLL_PHASE_POS_EN
            for (int i = 0; i < 4; i++) mpos[i] = '0;
`endif
        end
        m_a = sb.size() > 0 && sb[0].acc <= cyc;
        m_exp = {!m_a && pll_lock && !rst, 3'b000, last_sel, last_dir};
        m_d = 0;
        if (m_a) begin
            m_r = sb[0];
            m_d = cyc - m_r.acc + 1;
            m_exp[5] = 1'b1;
            m_exp[4] = m_d == m_r.d_done;
            m_exp[3] = m_r.cnt > 0 && m_d > S && m_d <= S + m_r.cnt * (P + T) && ((m_d - S - 1) % (P + T)) < P;
            m_exp[2:0] = {m_r.sel, m_r.dir};
        end
        m_act = {req_ready, busy, done, phasestep, phasesel, phasedir};
        checks++;
        if (m_act === m_exp) passes++;
        else $display("FAIL pins cyc=%0d d=%0d {ready,busy,done,step,sel,dir} got %b expected %b", cyc, m_d, m_act, m_exp);
        if (m_a && m_d >= m_r.d_done) begin
            void'(sb.pop_front());
            last_sel = m_r.sel;
            last_dir = m_r.dir;
`ifdef PLL_PHASE_POS_EN
            mpos[m_r.sel] = m_r.dir ? mpos[m_r.sel] - POS_W'(m_r.cnt) : mpos[m_r.sel] + POS_W'(m_r.cnt);
            checks++;
            if ({pos_os3, pos_os2, pos_os, pos_op} === {mpos[3], mpos[2], mpos[1], mpos[0]}) passes++;
            else $display("FAIL pos cyc=%0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", cyc,
                          pos_op, pos_os, pos_os2, pos_os3, mpos[0], mpos[1], mpos[2], mpos[3]);
`endif
        end
    end

    task automatic send(input logic [1:0] sel, input logic dir, input int cnt);
        req_t r;
        bit ok = 0;
        req_sel   = sel;
        req_dir   = dir;
        req_cnt   = CNT_W'(cnt);
        req_valid = 1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout ready got 0 expected 1 sel=%0d cnt=%0d", sel, cnt);
            req_valid = 0;
            return;
        end
        r.acc = cyc + 1;
        r.d_done = (cnt == 0) ? 1 : S + cnt * (P + T) + 1;
        r.sel = sel;
        r.dir = dir;
        r.cnt = cnt;
        sb.push_back(r);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout pending got %0d expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef PLL_PHASE_POS_EN
        for (int i = 0; i < 4; i++) mpos[i] = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 0;
        // request held while unlocked must not be taken
        req_sel = 1; req_dir = 0; req_cnt = 3; req_valid = 1;
        repeat (6) @(posedge clk);
        #1 pll_lock = 1;
        send(1, 0, 3);
        drain();
        send(0, 0, 0);
        drain();
        send(0, 1, 1);
        drain();
        send(0, 0, 9);
        drain();
        // reset during the second pulse of a five-step request
        send(2, 1, 5);
        repeat (S + P + T + 1) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        send(3, 0, 2);
        drain();
        // lock lost mid-request: steps still complete, acceptance waits for lock
        send(1, 1, 2);
        repeat (3) @(posedge clk);
        #1 pll_lock = 0;
        drain();
        repeat (4) @(posedge clk);
        #1 pll_lock = 1;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                pll_lock = 0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 pll_lock = 1;
            end
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1 pll_lock = 0;
                repeat ($urandom_range(1, 10)) @(posedge clk);
                #1 pll_lock = 1;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
Drives the dynamic phase-adjust pins (PHASESEL[1:0], PHASEDIR, PHASESTEP) of the ECP5 EHXPLLL from the fabric side, which the PLL instance currently ties to 0. It accepts phase-shift requests (output select, direction, step count) over a valid/ready handshake. It emits a correctly timed PHASESTEP pulse train, with setup and settle gaps between pulses. DDR3 read-capture and write-leveling calibration logic uses it to sweep clock phase in the PLL output clock domain.

Parameters:
SETUP_CYC, 4, cycles PHASESEL/PHASEDIR held stable before PHASESTEP rises (≥1)
PULSE_CYC, 4, cycles PHASESTEP held high per step (≥1)
SETTLE_CYC, 8, cycles after PHASESTEP falls before the next step or completion (≥1)
CNT_W, 8, width of step-count field
POS_W, 3, width of per-output position counter (8 steps = one VCO period)

Ports:
clk  in  1  PLL output clock; all logic on rising edge
rst  in  1  synchronous active-high reset
pll_lock  in  1  PLL LOCK status; requests are refused while low
req_valid  in  1  request valid
req_ready  out  1  block can accept a request
req_sel  in  2  PLL output to shift (0=CLKOP,1=CLKOS,2=CLKOS2,3=CLKOS3)
req_dir  in  1  0=delay (advance position), 1=lead (retreat position)
req_cnt  in  CNT_W  number of steps, 0 allowed
done  out  1  one-cycle pulse when a request completes
busy  out  1  request in progress
phasesel  out  2  to PLL PHASESEL[1:0]
phasedir  out  1  to PLL PHASEDIR
phasestep  out  1  to PLL PHASESTEP
pos_op, pos_os, pos_os2, pos_os3  out  POS_W each  accumulated position (only with optional feature)

Behaviour:
- Reset: state IDLE; req_ready=0 during reset cycle; done=0, busy=0, phasesel=0, phasedir=0, phasestep=0; pos_* = 0; step counter = 0.
- req_ready = (state==IDLE) & pll_lock & ~rst. Handshake fires on req_valid & req_ready; sel/dir/cnt registered at that edge.
- FSM: IDLE -> SETUP on accept with cnt≠0; IDLE -> DONE on accept with cnt=0 (no pulse issued). SETUP: phasesel/phasedir drive latched values, wait SETUP_CYC cycles -> PULSE. PULSE: phasestep=1 for exactly PULSE_CYC cycles -> SETTLE. SETTLE: phasestep=0 for SETTLE_CYC cycles; then decrement remaining count; if remaining becomes 0 -> DONE, else -> PULSE (sel/dir already stable, no repeated SETUP). DONE: done=1 for one cycle -> IDLE.
- busy=1 in SETUP, PULSE, SETTLE, DONE.
- phasesel/phasedir keep their last values in IDLE. They change only on the accept edge, never while phasestep=1.
- Latency: for cnt=N≥1, done asserts SETUP_CYC + N·(PULSE_CYC+SETTLE_CYC) + 1 cycles after the accept edge. For cnt=0, done asserts 1 cycle after accept.
- pll_lock falling mid-request: the current pulse completes normally and the remaining steps are still issued. Lock affects only acceptance of new requests.
- rst mid-request: all outputs return to reset values on that edge (phasestep forced low immediately). The request is abandoned with no done pulse.
- req_valid while busy: ignored. The requester holds it until ready.
- Internal cycle counters sized to clog2 of the max of the three *_CYC parameters, plus 1.

Optional Feature:
Macro PLL_PHASE_POS_EN. When defined: four POS_W position registers. Each pulse of the selected output adds 1 modulo 2^POS_W (dir=0) or subtracts 1 modulo 2^POS_W (dir=1), updated on the PHASESTEP falling edge (entering SETTLE). Registers wrap 7->0 and 0->7 at POS_W=3. When undefined: pos_* ports and registers are absent.

Decomposition:
- Shared package ddr3_pll_pkg holds:
  - FSM state enum (IDLE, SETUP, PULSE, SETTLE, DONE)
  - output-select constants SEL_OP/SEL_OS/SEL_OS2/SEL_OS3
  - direction constants DIR_DELAY/DIR_LEAD
- One natural sub-module, phase_pos_tracker: the per-output position counters, instantiated only under PLL_PHASE_POS_EN. The FSM stays in the top module.

Test Plan:
- Reset then pll_lock=1, request sel=1 dir=0 cnt=3 (defaults). Expect:
  - phasesel=1, phasedir=0 from accept+1
  - three 4-cycle phasestep pulses separated by 8-cycle gaps
  - done on cycle 4+3·12+1=41 after accept
  - pos_os=3
- cnt=0 request: done exactly 1 cycle after accept; phasestep never rises; busy high for one cycle.
- pll_lock=0 with req_valid=1: req_ready stays 0 and nothing issues. Raise lock: accept on the next edge.
- Position wrap (PLL_PHASE_POS_EN): sel=0 dir=1 cnt=1 from reset -> pos_op=7. Then dir=0 cnt=9 -> pos_op=0.
- Assert rst during the 2nd pulse of a cnt=5 request: phasestep=0 and busy=0 on the next edge; no done pulse; a subsequent request runs normally.
- Drop pll_lock during a cnt=2 request: both pulses complete and done fires. req_ready stays 0 until lock returns.
